// File: rtl/sid_cmd_pkg.sv
// sid_cmd_pkg: shared definitions for the SID command decoder.
//   - opcode encodings carried in command byte bits [7:5]
//   - reply codes sent back through the UART transmitter
//   - parser state type and state constants
//   - FIFO entry layout {sof, byte}
package sid_cmd_pkg;

    // Command opcodes; every other encoding is treated as unknown.
    localparam logic [2:0] OP_WRITE = 3'b000;
    localparam logic [2:0] OP_WAIT  = 3'b001;
    localparam logic [2:0] OP_PING  = 3'b010;

    // Reply bytes
    localparam logic [7:0] RPL_PING  = 8'h5A;
    localparam logic [7:0] RPL_TRUNC = 8'hEE;
    localparam logic [7:0] RPL_BADOP = 8'hEF;

    // Parser states
    typedef logic [2:0] parserState_t;

    localparam parserState_t S_OP    = 3'd0;
    localparam parserState_t S_WDATA = 3'd1;
    localparam parserState_t S_DLO   = 3'd2;
    localparam parserState_t S_DHI   = 3'd3;
    localparam parserState_t S_WAIT  = 3'd4;
    localparam parserState_t S_REPLY = 3'd5;

    // One FIFO slot: sof marks the first byte of a packet (or after a drop).
    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } fifoEntry_t;

endpackage

// File: rtl/sid_cmd_fifo.sv
// sid_cmd_fifo: synchronous FIFO of {sof, byte} entries.
//   clk       in   clock
//   rst       in   synchronous active-high reset (empties the FIFO)
//   push      in   write pushEntry this cycle (ignored when full without pop)
//   pushEntry in   entry to write
//   pop       in   discard the head entry (ignored when empty)
//   full      out  FifoDepth entries stored
//   empty     out  no entries stored
//   head      out  oldest entry; valid the cycle after it was pushed
module sid_cmd_fifo
    import sid_cmd_pkg::*;
#(
    parameter int unsigned FifoDepth = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  fifoEntry_t pushEntry,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output fifoEntry_t head
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wrPtr;
    logic [AW:0] rdPtr;
    fifoEntry_t  mem [FifoDepth];

    logic doPush;
    logic doPop;

    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

    assign doPop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush = push && (!full || doPop);

    assign head = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PtrOne;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[AW-1:0]] <= pushEntry;
        end
    end

endmodule

// File: rtl/sid_cmd_decoder.sv
// sid_cmd_decoder: parses the UART byte stream into SID register writes,
// timed waits and ping/error replies.
//   clk       in   sole clock
//   rst       in   synchronous active-high reset
//   rx_valid  in   one-cycle byte strobe from the receiver
//   rx_data   in   received byte
//   rx_eop    in   one-cycle end-of-packet strobe; next byte starts a packet
//   tx_start  out  one-cycle transmit request
//   tx_data   out  reply byte, held until the next reply
//   tx_busy   in   transmitter busy
//   sid_we    out  one-cycle SID write strobe
//   sid_addr  out  SID register address, held between writes
//   sid_data  out  SID write data, held between writes
//   busy      out  parser mid-command or FIFO non-empty
//   overflow  out  sticky: a received byte was dropped on a full FIFO
module sid_cmd_decoder
    import sid_cmd_pkg::*;
#(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned TickHz       = 1000000,
    parameter int unsigned FifoDepth    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_eop,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       sid_we,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned Div  = ClkFrequency / TickHz;
    localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);
    localparam logic [PreW-1:0] PreOne = {{(PreW-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------
    // Receive side: sof tagging and overflow detection
    // ---------------------------------------------------------------
    logic       fifoPush;
    logic       fifoPop;
    logic       fifoFull;
    logic       fifoEmpty;
    fifoEntry_t fifoHead;
    fifoEntry_t fifoIn;
    logic       sofPending;
    logic       overflowQ;
    logic       drop;

    assign fifoPush = rx_valid && (!fifoFull || fifoPop);
    assign drop     = rx_valid && fifoFull && !fifoPop;

    assign fifoIn.sof  = sofPending;
    assign fifoIn.data = rx_data;

    // A byte arriving together with rx_eop still belongs to the old packet;
    // the marker applies to the byte after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sofPending <= 1'b1;
            overflowQ  <= 1'b0;
        end else begin
            if (drop) begin
                overflowQ <= 1'b1;
            end
            if (drop || rx_eop) begin
                sofPending <= 1'b1;
            end else if (fifoPush) begin
                sofPending <= 1'b0;
            end
        end
    end

    sid_cmd_fifo #(
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifoPush),
        .pushEntry (fifoIn),
        .pop       (fifoPop),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .head      (fifoHead)
    );

    // ---------------------------------------------------------------
    // Parser
    // ---------------------------------------------------------------
    parserState_t state;
    parserState_t stateNext;

    logic [4:0]      cmdAddr;
    logic [7:0]      loByte;
    logic [15:0]     waitCount;
    logic [PreW-1:0] presc;
    logic [7:0]      txDataQ;
    logic            sidWeQ;
    logic [4:0]      sidAddrQ;
    logic [7:0]      sidDataQ;
    logic            guardQ;

    logic       txFire;
    logic       sidWeNext;
    logic       replyLoad;
    logic [7:0] replyNext;
    logic       cmdLoad;
    logic       loLoad;
    logic       waitLoad;
    logic       payloadOk;
    logic       truncate;

    // Payload states only consume bytes of the same packet; a head entry
    // with sof set is left in place to be parsed as the next command.
    assign payloadOk = !fifoEmpty && !fifoHead.sof;
    assign truncate  = !fifoEmpty && fifoHead.sof;

    always_comb begin
        stateNext = state;
        fifoPop   = 1'b0;
        txFire    = 1'b0;
        sidWeNext = 1'b0;
        replyLoad = 1'b0;
        replyNext = RPL_BADOP;
        cmdLoad   = 1'b0;
        loLoad    = 1'b0;
        waitLoad  = 1'b0;

        case (state)
            S_OP: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    case (fifoHead.data[7:5])
                        OP_WRITE: begin
                            cmdLoad   = 1'b1;
                            stateNext = S_WDATA;
                        end
                        OP_WAIT: begin
                            stateNext = S_DLO;
                        end
                        OP_PING: begin
                            replyLoad = 1'b1;
                            replyNext = RPL_PING;
                            stateNext = S_REPLY;
                        end
                        default: begin
                            replyLoad = 1'b1;
                            replyNext = RPL_BADOP;
                            stateNext = S_REPLY;
                        end
                    endcase
                end
            end

            S_WDATA, S_DLO, S_DHI: begin
                if (truncate) begin
                    replyLoad = 1'b1;
                    replyNext = RPL_TRUNC;
                    stateNext = S_REPLY;
                end else if (payloadOk) begin
                    fifoPop = 1'b1;
                    if (state == S_WDATA) begin
                        sidWeNext = 1'b1;
                        stateNext = S_OP;
                    end else if (state == S_DLO) begin
                        loLoad    = 1'b1;
                        stateNext = S_DHI;
                    end else begin
                        waitLoad  = 1'b1;
                        stateNext = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // N=0 leaves after one cycle; otherwise after N full
                // prescaler periods.
                if (waitCount == 16'd0) begin
                    stateNext = S_OP;
                end else if (presc == PreMax && waitCount == 16'd1) begin
                    stateNext = S_OP;
                end
            end

            S_REPLY: begin
                if (!tx_busy && !guardQ) begin
                    txFire    = 1'b1;
                    stateNext = S_OP;
                end
            end

            default: begin
                stateNext = S_OP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OP;
            cmdAddr   <= '0;
            loByte    <= '0;
            waitCount <= '0;
            presc     <= '0;
            txDataQ   <= '0;
            sidWeQ    <= 1'b0;
            sidAddrQ  <= '0;
            sidDataQ  <= '0;
            guardQ    <= 1'b0;
        end else begin
            state  <= stateNext;
            sidWeQ <= sidWeNext;
            // Blocks a second tx_start in the cycle right after one.
            guardQ <= txFire;

            if (cmdLoad) begin
                cmdAddr <= fifoHead.data[4:0];
            end
            if (loLoad) begin
                loByte <= fifoHead.data;
            end
            if (replyLoad) begin
                txDataQ <= replyNext;
            end
            if (sidWeNext) begin
                sidAddrQ <= cmdAddr;
                sidDataQ <= fifoHead.data;
            end

            if (waitLoad) begin
                waitCount <= {fifoHead.data, loByte};
                presc     <= '0;
            end else if (state == S_WAIT && waitCount != 16'd0) begin
                if (presc == PreMax) begin
                    presc     <= '0;
                    waitCount <= waitCount - 16'd1;
                end else begin
                    presc <= presc + PreOne;
                end
            end
        end
    end

    assign tx_start = txFire;
    assign tx_data  = txDataQ;
    assign sid_we   = sidWeQ;
    assign sid_addr = sidAddrQ;
    assign sid_data = sidDataQ;
    assign busy     = (state != S_OP) || !fifoEmpty;
    assign overflow = overflowQ;

endmodule

// File: tb/tb_sid_cmd_decoder.sv
module tb_sid_cmd_decoder;

    localparam int unsigned Div   = 4;
    localparam int unsigned Depth = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_eop;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       sid_we;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       busy;
    logic       overflow;

    sid_cmd_decoder #(
        .ClkFrequency (4000000),
        .TickHz       (1000000),
        .FifoDepth    (Depth)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_eop   (rx_eop),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .sid_we   (sid_we),
        .sid_addr (sid_addr),
        .sid_data (sid_data),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastPushCyc = 0;
    int weCyc = 0;
    int txCyc = 0;
    int weCount = 0;
    int txCount = 0;
    logic prevWe = 1'b0;
    logic prevTx = 1'b0;

    // Scoreboard: expected writes {addr, data} and expected reply bytes.
    logic [12:0] expWr[$];
    logic [7:0]  expRpl[$];
    logic [12:0] wantWr;
    logic [7:0]  wantRpl;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (sid_we) begin
                weCount++;
                weCyc = cyc;
                checks++;
                if (expWr.size() == 0) begin
                    errors++;
                    $display("FAIL sid_we_unexpected: got addr=%h data=%h, required no write",
                             sid_addr, sid_data);
                end else begin
                    wantWr = expWr.pop_front();
                    if ({sid_addr, sid_data} !== wantWr) begin
                        errors++;
                        $display("FAIL sid_write: got addr=%h data=%h, required addr=%h data=%h",
                                 sid_addr, sid_data, wantWr[12:8], wantWr[7:0]);
                    end
                end
                checks++;
                if (prevWe) begin
                    errors++;
                    $display("FAIL sid_we_width: got 2 consecutive cycles, required 1");
                end
            end
            if (tx_start) begin
                txCount++;
                txCyc = cyc;
                checks++;
                if (expRpl.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got tx_data=%h, required no reply", tx_data);
                end else begin
                    wantRpl = expRpl.pop_front();
                    if (tx_data !== wantRpl) begin
                        errors++;
                        $display("FAIL tx_reply: got %h, required %h", tx_data, wantRpl);
                    end
                end
                checks++;
                if (prevTx) begin
                    errors++;
                    $display("FAIL tx_start_width: got 2 consecutive cycles, required 1");
                end
            end
        end
        prevWe = sid_we;
        prevTx = tx_start;
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic pushByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        lastPushCyc = cyc;
    endtask

    task automatic pulseEop();
        rx_eop = 1'b1;
        @(posedge clk);
        #1;
        rx_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitQueues(input int budget, input bit needIdle, input string name);
        int n = 0;
        while ((expWr.size() != 0 || expRpl.size() != 0 || (needIdle && busy)) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (expWr.size() != 0 || expRpl.size() != 0 || (needIdle && busy)) begin
            errors++;
            $display("FAIL %s_timeout: got %0d writes %0d replies pending busy=%b, required none",
                     name, expWr.size(), expRpl.size(), busy);
            expWr.delete();
            expRpl.delete();
        end
    endtask

    task automatic checkAllZero(input string name);
        checks++;
        if ({tx_start, tx_data, sid_we, sid_addr, sid_data} !== 23'd0) begin
            errors++;
            $display("FAIL %s_outputs: got tx_start=%b tx_data=%h sid_we=%b addr=%h data=%h, required 0",
                     name, tx_start, tx_data, sid_we, sid_addr, sid_data);
        end
        checks++;
        if ({busy, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL %s_status: got busy=%b overflow=%b, required 0 0", name, busy, overflow);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkAllZero("reset");
    endtask

    task automatic test_write();
        int k;
        int t0;
        t0 = txCount;
        expWr.push_back({5'h18, 8'h0F});
        pushByte(8'h18);
        pushByte(8'h0F);
        k = lastPushCyc;
        waitQueues(50, 1'b1, "write");
        checks++;
        if (weCyc !== k + 1) begin
            errors++;
            $display("FAIL write_latency: got cycle %0d, required %0d", weCyc, k + 1);
        end
        checks++;
        if (txCount !== t0) begin
            errors++;
            $display("FAIL write_no_reply: got %0d tx_start, required %0d", txCount - t0, 0);
        end
    endtask

    task automatic test_wait(input int n);
        int k;
        int want;
        logic [15:0] nv;
        nv = 16'(n);
        pushByte(8'h20);
        pushByte(nv[7:0]);
        pushByte(nv[15:8]);
        k = lastPushCyc;
        expWr.push_back({5'h01, 8'hAA});
        pushByte(8'h01);
        pushByte(8'hAA);
        waitQueues(200, 1'b1, "wait");
        // hi byte pops one cycle after it lands, then the wait, then 2 cycles to sid_we
        want = k + 3 + ((n == 0) ? 1 : n * Div);
        checks++;
        if (weCyc !== want) begin
            errors++;
            $display("FAIL wait_n%0d_timing: got sid_we at cycle %0d, required %0d", n, weCyc, want);
        end
    endtask

    task automatic test_ping_backpressure();
        int t0;
        t0 = txCount;
        tx_busy = 1'b1;
        pushByte(8'h40);
        idle(10);
        checks++;
        if (txCount !== t0) begin
            errors++;
            $display("FAIL ping_held: got %0d tx_start while busy, required 0", txCount - t0);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ping_busy: got busy=%b, required 1", busy);
        end
        expRpl.push_back(8'h5A);
        tx_busy = 1'b0;
        waitQueues(20, 1'b1, "ping");
        idle(5);
        checks++;
        if (txCount !== t0 + 1) begin
            errors++;
            $display("FAIL ping_single: got %0d tx_start, required 1", txCount - t0);
        end
    endtask

    task automatic test_truncation();
        int w0;
        w0 = weCount;
        expRpl.push_back(8'hEE);
        expWr.push_back({5'h06, 8'h33});
        pushByte(8'h05);
        pulseEop();
        pushByte(8'h06);
        pushByte(8'h33);
        waitQueues(50, 1'b1, "trunc");
        checks++;
        if (weCount !== w0 + 1) begin
            errors++;
            $display("FAIL trunc_writes: got %0d writes, required 1", weCount - w0);
        end
    endtask

    task automatic test_overflow();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_initial: got %b, required 0", overflow);
        end
        // WAIT N=1000
        pushByte(8'h20);
        pushByte(8'hE8);
        pushByte(8'h03);
        idle(5);
        for (int i = 0; i < 7; i++) begin
            expWr.push_back({5'(8 + i), 8'(16 + i)});
        end
        expRpl.push_back(8'h5A);
        for (int i = 0; i < 7; i++) begin
            pushByte(8'(8 + i));
            pushByte(8'(16 + i));
        end
        pushByte(8'h40);
        pushByte(8'h03);
        // FIFO is now full: these two are dropped
        pushByte(8'hFF);
        pushByte(8'hFF);
        idle(1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b, required 1", overflow);
        end
        waitQueues(6000, 1'b0, "overflow_drain");
        idle(5);
        // The trailing WRITE 0x03 is cut by the sof on the next accepted byte.
        expRpl.push_back(8'hEE);
        expWr.push_back({5'h04, 8'h77});
        pushByte(8'h04);
        pushByte(8'h77);
        waitQueues(50, 1'b1, "overflow_resync");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b, required 1", overflow);
        end
    endtask

    task automatic test_badop_then_reset();
        int k;
        int t0;
        int w0;
        expRpl.push_back(8'hEF);
        pushByte(8'hE0);
        k = lastPushCyc;
        waitQueues(50, 1'b1, "badop");
        checks++;
        if (txCyc !== k + 1) begin
            errors++;
            $display("FAIL badop_latency: got cycle %0d, required %0d", txCyc, k + 1);
        end
        pushByte(8'h20);
        pushByte(8'hE8);
        pushByte(8'h03);
        pushByte(8'h40);
        idle(20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkAllZero("midwait_reset");
        t0 = txCount;
        w0 = weCount;
        idle(60);
        checks++;
        if (txCount !== t0 || weCount !== w0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d replies %0d writes, required 0 0",
                     txCount - t0, weCount - w0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_eop   = 1'b0;
        tx_busy  = 1'b0;
        test_reset();
        test_write();
        test_wait(3);
        test_wait(0);
        test_ping_backpressure();
        test_truncation();
        test_overflow();
        test_badop_then_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
